// File: rtl/pipemem_stage.sv
// pipemem_stage: MEM pipeline stage with stalling bus access, timeout abort and MEM/WB register
module pipemem_stage #(
  parameter int TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        mwreg,
  input  logic        mm2reg,
  input  logic        mwmem,
  input  logic [31:0] malu,
  input  logic [31:0] mb,
  input  logic [4:0]  mrn,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        mem_stall,
  output logic        wwreg,
  output logic        wm2reg,
  output logic [4:0]  wrn,
  output logic [31:0] walu,
  output logic [31:0] wmo,
  output logic        timeout_err
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_n;
  logic [7:0] cnt;
  logic access, hit;
  assign access    = mm2reg | mwmem;
  assign hit       = state == WAIT && !bus_ack && cnt == 8'(TIMEOUT - 1);
  assign mem_stall = (state == IDLE && access) || (state == WAIT && !bus_ack && !hit);
  assign bus_we    = mwmem;
  assign bus_addr  = {malu[31:2], 2'b00};
  assign bus_wdata = mb;
  // next state: start an access from IDLE, leave WAIT on ack or timeout
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (access ? WAIT : IDLE) : ((bus_ack || hit) ? IDLE : WAIT);
  end
  // state register
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  // bus request, wait counter (cleared outside WAIT so every entry starts at 0) and sticky error
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      bus_req     <= 1'b0;
      cnt         <= 8'd0;
      timeout_err <= 1'b0;
    end else begin
      bus_req     <= state_n == WAIT;
      cnt         <= (state == WAIT && mem_stall) ? cnt + 8'd1 : 8'd0;
      timeout_err <= timeout_err | hit;
    end
  // MEM/WB register: retire when not stalled, bubble otherwise; a timed-out access writes nothing
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      wwreg  <= 1'b0;
      wm2reg <= 1'b0;
      wrn    <= 5'd0;
      walu   <= 32'h0;
      wmo    <= 32'h0;
    end else if (!mem_stall) begin
      wwreg  <= mwreg & !hit;
      wm2reg <= mm2reg & !hit;
      wrn    <= mrn;
      walu   <= malu;
      wmo    <= hit ? 32'h0 : (state == WAIT && bus_ack && mm2reg) ? bus_rdata : wmo;
    end else begin
      wwreg  <= 1'b0;
      wm2reg <= 1'b0;
    end
endmodule

// File: tb/tb_pipemem_stage.sv
// tb_pipemem_stage: randomized instruction stream against a transaction-level model of the MEM stage
module tb_pipemem_stage;
  localparam int TO = 15;
  logic clock = 1'b0, resetn = 1'b0;
  logic mwreg = 0, mm2reg = 0, mwmem = 0, bus_ack = 0;
  logic [31:0] malu = 0, mb = 0, bus_rdata = 0;
  logic [4:0] mrn = 0;
  logic bus_req, bus_we, mem_stall, wwreg, wm2reg, timeout_err;
  logic [31:0] bus_addr, bus_wdata, walu, wmo;
  logic [4:0] wrn;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] m_wmo = 0;
  logic m_terr = 0;

  pipemem_stage #(.TIMEOUT(TO)) dut (
    .clock(clock), .resetn(resetn), .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
    .malu(malu), .mb(mb), .mrn(mrn), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .mem_stall(mem_stall), .wwreg(wwreg), .wm2reg(wm2reg), .wrn(wrn), .walu(walu),
    .wmo(wmo), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // kind 0=ALU 1=load 2=store; d = non-ack WAIT cycles before ack (>=TO means never acked)
  task automatic run_instr(input int kind, input logic wr, input logic [31:0] alu,
                           input logic [31:0] data, input logic [4:0] rn, input int d,
                           input logic [31:0] rd, input logic noise);
    int k = 0, stalls = 0;
    bit acc = kind != 0, tout = kind != 0 && d >= TO;
    int exp_stalls = !acc ? 0 : tout ? TO : d + 1;
    mwreg = kind == 2 ? 1'b0 : wr;
    mm2reg = kind == 1;
    mwmem = kind == 2;
    malu = alu; mb = data; mrn = rn; bus_rdata = rd;
    forever begin
      bus_ack = (acc && k == d + 1) || (k == 0 && noise);
      #1;
      if (k == 0) begin
        check("bus_addr", bus_addr, {alu[31:2], 2'b00});
        check("bus_we", 32'(bus_we), 32'(kind == 2));
        check("bus_wdata", bus_wdata, data);
      end
      if (!mem_stall) break;
      stalls++;
      if (k > 300) begin
        check("budget_stall", 32'(mem_stall), 0);
        break;
      end
      @(posedge clock); #1;
      check("bubble_wwreg", 32'(wwreg), 0);
      check("wait_bus_req", 32'(bus_req), 1);
      @(negedge clock);
      k++;
    end
    @(posedge clock); #1;
    if (tout) m_wmo = 0;
    else if (kind == 1) m_wmo = rd;
    m_terr |= tout;
    check("stall_cycles", stalls, exp_stalls);
    check("wwreg", 32'(wwreg), 32'(!tout && mwreg));
    check("wm2reg", 32'(wm2reg), 32'(!tout && kind == 1));
    check("wrn", 32'(wrn), 32'(rn));
    check("walu", walu, alu);
    check("wmo", wmo, m_wmo);
    check("timeout_err", 32'(timeout_err), 32'(m_terr));
    check("bus_req_idle", 32'(bus_req), 0);
    @(negedge clock);
    bus_ack = 0; mwreg = 0; mm2reg = 0; mwmem = 0;
  endtask

  initial begin
    #2;
    check("rst_bus_req", 32'(bus_req), 0);
    check("rst_stall", 32'(mem_stall), 0);
    check("rst_wwreg", 32'(wwreg), 0);
    check("rst_wmo", wmo, 0);
    check("rst_walu", walu, 0);
    check("rst_terr", 32'(timeout_err), 0);
    @(negedge clock); resetn = 1;
    @(negedge clock);
    run_instr(0, 1, 32'h1234, 0, 5, 0, 0, 0);
    run_instr(1, 1, 32'h40, 0, 7, 0, 32'hCAFEF00D, 1);
    run_instr(2, 0, 32'h47, 32'hA5A5A5A5, 3, 2, 32'h11111111, 0);
    run_instr(1, 1, 32'h80, 0, 9, TO - 1, 32'h0BADBEEF, 0);
    check("no_err_late_ack", 32'(timeout_err), 0);
    run_instr(1, 1, 32'h100, 0, 4, 255, 32'hDEADDEAD, 0);
    run_instr(0, 1, 32'h55, 0, 6, 0, 0, 1);
    for (int i = 0; i < 60; i++) begin
      int kind = $urandom_range(0, 2);
      int r = $urandom_range(0, 9);
      int d = r == 0 ? 255 : r == 1 ? TO - 1 : $urandom_range(0, 4);
      run_instr(kind, 1'($urandom), $urandom, $urandom, 5'($urandom), d, $urandom, 1'($urandom));
    end
    mm2reg = 1; malu = 32'h200; mrn = 8;
    @(posedge clock); @(posedge clock); #2;
    resetn = 0; #1;
    check("mid_rst_bus_req", 32'(bus_req), 0);
    check("mid_rst_terr", 32'(timeout_err), 0);
    check("mid_rst_wwreg", 32'(wwreg), 0);
    check("mid_rst_wm2reg", 32'(wm2reg), 0);
    check("mid_rst_wrn", 32'(wrn), 0);
    check("mid_rst_walu", walu, 0);
    check("mid_rst_wmo", wmo, 0);
    mm2reg = 0; m_wmo = 0; m_terr = 0;
    @(negedge clock); resetn = 1; bus_ack = 1; bus_rdata = 32'h77777777;
    #1;
    check("post_rst_stall", 32'(mem_stall), 0);
    @(posedge clock); #1;
    check("post_rst_ack_ignored", wmo, 0);
    check("post_rst_bus_req", 32'(bus_req), 0);
    @(negedge clock); bus_ack = 0;
    run_instr(1, 1, 32'h300, 0, 2, 1, 32'h12345678, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipemem_stage.md
PIPEMEM_STAGE -- requirements
Module: pipemem_stage

Interface
REQ-001 Parameter TIMEOUT, default 15, max WAIT cycles before an access is aborted (1..255).
REQ-002 clock  in  1  rising-edge clock.
REQ-003 resetn  in  1  reset, asynchronous, active-low.
REQ-004 mwreg, mm2reg, mwmem  in  1 each  MEM-stage control: register write, load, store.
REQ-005 malu  in  32  ALU result / effective address.
REQ-006 mb  in  32  store data.
REQ-007 mrn  in  5  destination register number.
REQ-008 bus_req  out  1  access request, registered.
REQ-009 bus_we  out  1  store qualifier, equals mwmem.
REQ-010 bus_addr  out  32  word address {malu[31:2],2'b00}.
REQ-011 bus_wdata  out  32  equals mb.
REQ-012 bus_ack  in  1  single-cycle completion strobe.
REQ-013 bus_rdata  in  32  load data, valid when bus_ack=1.
REQ-014 mem_stall  out  1  freeze request to IF/ID/EXE stages and the EXE/MEM register.
REQ-015 wwreg, wm2reg  out  1 each  MEM/WB control.
REQ-016 wrn  out  5  MEM/WB destination register.
REQ-017 walu, wmo  out  32 each  MEM/WB ALU result and load data.
REQ-018 timeout_err  out  1  sticky bus-timeout flag.

Function
REQ-019 Access = mm2reg|mwmem; FSM states IDLE and WAIT only.
REQ-020 IDLE: access=1 -> WAIT on next edge and bus_req<=1; access=0 -> stay IDLE.
REQ-021 WAIT: bus_ack=1 -> IDLE, bus_req<=0; bus_ack=0 and wait counter=TIMEOUT-1 -> IDLE, bus_req<=0, timeout_err<=1; else stay, counter+1.
REQ-022 Wait counter 8-bit, cleared on every WAIT entry; never wraps.
REQ-023 bus_ack in IDLE ignored; ack and timeout in same cycle -> ack wins, no timeout_err.
REQ-024 mem_stall combinational = (IDLE & access) | (WAIT & ~bus_ack & ~timeout_hit).
REQ-025 Non-access instruction: zero stall cycles, 1-cycle MEM latency.
REQ-026 Access: minimum 1 stall cycle; stall cycles = 1 + cycles from bus_req rise to bus_ack.
REQ-027 MEM/WB register, edge with mem_stall=0: wwreg<=mwreg, wm2reg<=mm2reg, wrn<=mrn, walu<=malu, wmo<=(WAIT&bus_ack)?bus_rdata:wmo.
REQ-028 Edge with mem_stall=1: wwreg<=0, wm2reg<=0 (bubble); wrn, walu, wmo hold.
REQ-029 Timeout abort: instruction retires with wwreg<=0, wm2reg<=0, wmo<=32'h0 (no register write).
REQ-030 bus_addr/bus_wdata/bus_we combinational from inputs; inputs guaranteed stable while mem_stall=1.
REQ-031 Store retires with wmo unchanged.
REQ-032 timeout_err clears only on reset.

Reset
REQ-033 resetn=0 immediately: state IDLE, counter 0, bus_req 0, timeout_err 0, wwreg/wm2reg 0, wrn 0, walu/wmo 32'h0.
REQ-034 Reset mid-WAIT abandons access; bus_req drops asynchronously; no retire.
REQ-035 mem_stall after reset follows REQ-024 from inputs only.

Verification
REQ-036 ALU op mwreg=1, malu=32'h1234, mrn=5 -> no stall; next edge wwreg=1, walu=32'h1234, wrn=5.
REQ-037 Load malu=32'h40, bus_ack one cycle after bus_req -> 1 stall cycle; bus_addr=32'h40; wmo=bus_rdata=32'hCAFEF00D, wm2reg=1, wwreg per mwreg.
REQ-038 Store malu=32'h47, mb=32'hA5A5A5A5, ack after 3 WAIT cycles -> bus_addr=32'h44, bus_we=1, 3 stall cycles, bubbles meanwhile, wwreg=0 at retire.
REQ-039 Load with no ack, TIMEOUT=15 -> 15 WAIT cycles, timeout_err=1 sticky, retire with wwreg=0, wmo=0; next ALU op unaffected.
REQ-040 Ack on cycle TIMEOUT-1 -> load completes, timeout_err stays 0.
REQ-041 resetn pulsed low in 2nd WAIT cycle -> bus_req=0 at once, all outputs at REQ-033 values, later ack ignored.
